// File: rtl/if_fetch_if.sv
// Instruction-memory bus between the fetch stage and the instruction memory.
// A single request is accepted on req & gnt; its data returns later on rvalid.
interface if_fetch_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              req;
   logic [ADDR_W-1:0] addr;
   logic              gnt;
   logic              rvalid;
   logic [DATA_W-1:0] rdata;

   modport master (
      output req, addr,
      input  gnt, rvalid, rdata
   );

   modport slave (
      input  req, addr,
      output gnt, rvalid, rdata
   );
endinterface

// File: rtl/if_fetch.sv
// Instruction fetch stage: one outstanding imem request at a time, IF/ID register,
// PC freeze request while a fetch is in flight, and wrong-path discard on a taken branch.
module if_fetch #(
   parameter int                ADDR_W  = 32,
   parameter int                DATA_W  = 32,
   parameter int                STALL_W = 6,
   parameter logic [DATA_W-1:0] NOP     = 32'h0000_0013
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [STALL_W-1:0] stall_i,
   input  logic               flush_i,
   input  logic [ADDR_W-1:0]  pc_i,
   if_fetch_if.master         imem,
   output logic               stallreq_o,
   output logic [ADDR_W-1:0]  id_pc_o,
   output logic [DATA_W-1:0]  id_inst_o,
   output logic               id_valid_o
);

   typedef enum logic [1:0] {
      REQ,
      WAIT,
      HOLD,
      DROP
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [ADDR_W-1:0] pend_pc;
   logic [ADDR_W-1:0] buf_pc;
   logic [DATA_W-1:0] buf_inst;
   logic              buf_we;
   logic              load;
   logic [ADDR_W-1:0] load_pc;
   logic [DATA_W-1:0] load_inst;
   logic              hold_id;
   logic              unused_stall;

   assign hold_id      = stall_i[1];
   assign unused_stall = ^{stall_i[STALL_W-1:2], stall_i[0]};

   // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latch).
   always_comb begin
      state_nxt = state;
      buf_we    = 1'b0;
      load      = 1'b0;
      load_pc   = pend_pc;
      load_inst = imem.rdata;
      case (state)
         REQ: begin
            if (imem.gnt) state_nxt = flush_i ? DROP : WAIT;
         end
         WAIT: begin
            if (imem.rvalid) begin
               if (flush_i) begin
                  state_nxt = REQ;
               end else if (hold_id) begin
                  buf_we    = 1'b1;
                  state_nxt = HOLD;
               end else begin
                  load      = 1'b1;
                  state_nxt = REQ;
               end
            end else if (flush_i) begin
               state_nxt = DROP;
            end
         end
         HOLD: begin
            if (flush_i) begin
               state_nxt = REQ;
            end else if (!hold_id) begin
               load      = 1'b1;
               load_pc   = buf_pc;
               load_inst = buf_inst;
               state_nxt = REQ;
            end
         end
         DROP: begin
            // The wrong-path response must still be absorbed before a new request.
            if (imem.rvalid) state_nxt = REQ;
         end
         default: state_nxt = REQ;
      endcase
   end

   assign imem.req   = !rst && (state == REQ);
   assign imem.addr  = pc_i;
   assign stallreq_o = !rst && !load && !flush_i;

   // NOTE: sequential state uses non-blocking assignments so all registers update together on the edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= REQ;
         pend_pc    <= '0;
         buf_pc     <= '0;
         buf_inst   <= NOP;
         id_pc_o    <= '0;
         id_inst_o  <= NOP;
         id_valid_o <= 1'b0;
      end else begin
         state <= state_nxt;
         if ((state == REQ) && imem.gnt && !flush_i) pend_pc <= pc_i;
         if (buf_we) begin
            buf_pc   <= pend_pc;
            buf_inst <= imem.rdata;
         end
         if (flush_i) begin
            id_valid_o <= 1'b0;
            id_inst_o  <= NOP;
         end else if (!hold_id) begin
            if (load) begin
               id_pc_o    <= load_pc;
               id_inst_o  <= load_inst;
               id_valid_o <= 1'b1;
            end else begin
               id_valid_o <= 1'b0;
               id_inst_o  <= NOP;
            end
         end
      end
   end

endmodule
